// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq - registered, handshaked ALU for the execute path.
//
// Accepts one operation per valid/ready transfer, registers the result and
// its status flags, and holds them until the consumer takes them. Supports
// ADD, SUB, AND, OR, XOR, NOR, SRA, SRL, SLL, SLT and, when the macro
// ALU_SEQ_MUL_EN is defined, an iterative signed shift-add MUL. Without the
// macro, MUL is reported as an unsupported opcode.
//
// Ports:
//   i_clk               clock, all state on the rising edge
//   i_reset             asynchronous active-high reset
//   i_valid / o_ready   operation handshake (o_ready is combinational)
//   i_op                opcode (function-field encoding)
//   i_data_A, i_data_B  signed operands
//   o_valid / i_ready   result handshake
//   o_data              signed result
//   o_zero              o_data == 0
//   o_ovf               signed overflow (ADD/SUB/MUL)
//   o_carry             ADD carry-out / SUB borrow
//   o_err               unsupported opcode (o_data forced to 0)
// ---------------------------------------------------------------------------
module alu_seq #(
   parameter int NB_OP   = 6,
   parameter int NB_DATA = 8
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic [NB_OP-1:0]          i_op,
   input  logic signed [NB_DATA-1:0] i_data_A,
   input  logic signed [NB_DATA-1:0] i_data_B,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic signed [NB_DATA-1:0] o_data,
   output logic                      o_zero,
   output logic                      o_ovf,
   output logic                      o_carry,
   output logic                      o_err
);

   localparam int NB_SH = $clog2(NB_DATA);

   localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
   localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
   localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
   localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
   localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
   localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
   localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
   localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
   localparam logic [NB_OP-1:0] OP_SLL = NB_OP'(6'b000000);
   localparam logic [NB_OP-1:0] OP_SLT = NB_OP'(6'b101010);
`ifdef ALU_SEQ_MUL_EN
   localparam logic [NB_OP-1:0] OP_MUL = NB_OP'(6'b011000);
`endif

`ifdef ALU_SEQ_MUL_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_FULL = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_FULL = 2'd2} state_t;
`endif

   // Signed overflow: same-sign operands with a result of the other sign.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

   // Signed overflow on A-B: operands of opposite sign, result sign != A sign.
   function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb != b_msb) && (r_msb != a_msb);
   endfunction

   state_t state_q, state_d;

   logic                      accept;
   logic                      load_res;
   logic signed [NB_DATA-1:0] alu_data;
   logic                      alu_ovf;
   logic                      alu_carry;
   logic                      alu_err;
   logic [NB_SH-1:0]          sh_amt;
   logic [NB_DATA:0]          add_u;
   logic [NB_DATA:0]          sub_u;

   logic signed [NB_DATA-1:0] data_q;
   logic                      zero_q;
   logic                      ovf_q;
   logic                      carry_q;
   logic                      err_q;

   assign o_ready = (state_q == S_IDLE) || ((state_q == S_FULL) && i_ready);
   assign o_valid = (state_q == S_FULL);
   assign accept  = i_valid && o_ready;

   assign o_data  = data_q;
   assign o_zero  = zero_q;
   assign o_ovf   = ovf_q;
   assign o_carry = carry_q;
   assign o_err   = err_q;

   // Only the low bits of B select the shift distance.
   assign sh_amt = i_data_B[NB_SH-1:0];
   // Unsigned NB_DATA+1 arithmetic: the top bit is carry (ADD) or borrow (SUB).
   assign add_u  = {1'b0, i_data_A} + {1'b0, i_data_B};
   assign sub_u  = {1'b0, i_data_A} - {1'b0, i_data_B};

`ifdef ALU_SEQ_MUL_EN
   logic                        alu_mul;
   logic                        load_mul;
   logic                        fin_mul;
   logic [2*NB_DATA-1:0]        mcand_q;
   logic [NB_DATA-1:0]          mplier_q;
   logic [2*NB_DATA-1:0]        acc_q;
   logic                        neg_q;
   logic [NB_SH-1:0]            cnt_q;
   logic                        last_q;
   logic signed [2*NB_DATA-1:0] prod;

   // Magnitude of a signed operand; the most negative value maps to 2^(N-1).
   function automatic logic [NB_DATA-1:0] mag(input logic signed [NB_DATA-1:0] v);
      return v[NB_DATA-1] ? NB_DATA'(-v) : NB_DATA'(v);
   endfunction

   // True when the double-width product fits in NB_DATA signed bits.
   function automatic logic fits_signed(input logic [2*NB_DATA-1:0] p);
      logic [NB_DATA:0] top;
      top = p[2*NB_DATA-1:NB_DATA-1];
      return (top == '0) || (top == '1);
   endfunction

   assign prod = neg_q ? -$signed(acc_q) : $signed(acc_q);
`endif

   always_comb begin
      alu_data  = '0;
      alu_ovf   = 1'b0;
      alu_carry = 1'b0;
      alu_err   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      alu_mul   = 1'b0;
`endif
      case (i_op)
         OP_ADD: begin
            alu_data  = add_u[NB_DATA-1:0];
            alu_carry = add_u[NB_DATA];
            alu_ovf   = add_ovf(i_data_A[NB_DATA-1], i_data_B[NB_DATA-1], add_u[NB_DATA-1]);
         end
         OP_SUB: begin
            alu_data  = sub_u[NB_DATA-1:0];
            alu_carry = sub_u[NB_DATA];
            alu_ovf   = sub_ovf(i_data_A[NB_DATA-1], i_data_B[NB_DATA-1], sub_u[NB_DATA-1]);
         end
         OP_AND: alu_data = i_data_A & i_data_B;
         OP_OR:  alu_data = i_data_A | i_data_B;
         OP_XOR: alu_data = i_data_A ^ i_data_B;
         OP_NOR: alu_data = ~(i_data_A | i_data_B);
         OP_SRA: alu_data = i_data_A >>> sh_amt;
         OP_SRL: alu_data = $signed($unsigned(i_data_A) >> sh_amt);
         OP_SLL: alu_data = i_data_A << sh_amt;
         OP_SLT: alu_data = {{(NB_DATA-1){1'b0}}, (i_data_A < i_data_B)};
`ifdef ALU_SEQ_MUL_EN
         OP_MUL: alu_mul = 1'b1;
`endif
         default: alu_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      load_res = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      load_mul = 1'b0;
      fin_mul  = 1'b0;
`endif
      case (state_q)
         S_IDLE, S_FULL: begin
            // In FULL, accept already implies i_ready, so the old result
            // retires on the same edge that the new one is loaded.
            if (accept) begin
`ifdef ALU_SEQ_MUL_EN
               if (alu_mul) begin
                  state_d  = S_BUSY;
                  load_mul = 1'b1;
               end else begin
                  state_d  = S_FULL;
                  load_res = 1'b1;
               end
`else
               state_d  = S_FULL;
               load_res = 1'b1;
`endif
            end else if ((state_q == S_FULL) && i_ready) begin
               state_d = S_IDLE;
            end
         end
`ifdef ALU_SEQ_MUL_EN
         S_BUSY: begin
            // last_q marks the accumulator complete; this edge applies the
            // sign and forms the flags.
            if (last_q) begin
               state_d = S_FULL;
               fin_mul = 1'b1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // ---- output register stage ----
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load_res) begin
            data_q  <= alu_data;
            zero_q  <= (alu_data == '0);
            ovf_q   <= alu_ovf;
            carry_q <= alu_carry;
            err_q   <= alu_err;
         end
`ifdef ALU_SEQ_MUL_EN
         else if (fin_mul) begin
            data_q  <= prod[NB_DATA-1:0];
            zero_q  <= (prod[NB_DATA-1:0] == '0);
            ovf_q   <= !fits_signed(prod);
            carry_q <= 1'b0;
            err_q   <= 1'b0;
         end
`endif
      end
   end

`ifdef ALU_SEQ_MUL_EN
   // ---- multiply iteration stage ----
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_q  <= '0;
         last_q <= 1'b0;
      end else if (load_mul) begin
         cnt_q  <= '0;
         last_q <= 1'b0;
      end else if ((state_q == S_BUSY) && !last_q) begin
         if (cnt_q == NB_SH'(NB_DATA-1)) begin
            last_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (load_mul) begin
         mcand_q  <= {{NB_DATA{1'b0}}, mag(i_data_A)};
         mplier_q <= mag(i_data_B);
         acc_q    <= '0;
         neg_q    <= i_data_A[NB_DATA-1] ^ i_data_B[NB_DATA-1];
      end else if ((state_q == S_BUSY) && !last_q) begin
         if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
         end
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
      end
   end
`endif

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, handshaked ALU; the parametrised successor to the combinational ALU in the execute path. It accepts one operation per transfer over valid/ready, produces a registered result plus status flags, and holds the result under back-pressure. It adds SLL, SLT and an optional iterative signed multiply. It sits between the operand/opcode source (switch/UART front-end or decode stage) and the result consumer.

## Interface
- NB_OP, 6, opcode width (function-field encoding)
- NB_DATA, 8, operand/result width, ≥4; shift amount width NB_SH = clog2(NB_DATA) (localparam)
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  reset, asynchronous, active-high
- i_valid  in  1  operation offered
- o_ready  out  1  block can accept this cycle (combinational)
- i_op  in  NB_OP  opcode
- i_data_A  in  NB_DATA  signed operand A
- i_data_B  in  NB_DATA  signed operand B
- o_valid  out  1  result held in output register
- i_ready  in  1  consumer takes result this cycle
- o_data  out  NB_DATA  signed result
- o_zero  out  1  o_data == 0
- o_ovf  out  1  signed overflow (ADD/SUB/MUL), else 0
- o_carry  out  1  ADD carry-out / SUB borrow, else 0
- o_err  out  1  opcode unsupported; o_data = 0, flags other than o_zero = 0

## Operation
- Opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010, SLL 000000, SLT 101010, MUL 011000. Any other opcode -> o_err.
- Shifts use only B[NB_SH-1:0] as an unsigned amount; upper B bits are ignored. SRA fills with A's MSB, SRL and SLL fill with 0.
- SLT: result 1 if A < B (signed), else 0.
- ADD/SUB are computed at NB_DATA+1 bits. o_carry is bit NB_DATA of the unsigned sum/difference. o_ovf is set when the operand signs are such that the result sign is wrong.
- MUL: shift-add on |A|×|B| over NB_DATA iterations into a 2·NB_DATA accumulator, negated if the signs differ. o_data is the low NB_DATA bits. o_ovf is set if the full product is not representable in NB_DATA signed bits.
- Operands and opcode are captured at accept (i_valid && o_ready). Later input changes have no effect.
- FSM states:
  - IDLE: output register empty.
  - BUSY: MUL iterating; counter runs 0..NB_DATA-1.
  - FULL: result valid.
- FSM transitions:
  - IDLE –accept non-MUL–> FULL.
  - IDLE –accept MUL–> BUSY.
  - BUSY –count==NB_DATA-1–> FULL.
  - FULL –i_ready, no accept–> IDLE.
  - FULL –i_ready + accept–> FULL (non-MUL) or BUSY (MUL).
- o_ready = (state==IDLE) || (state==FULL && i_ready). It is 0 in BUSY.
- o_valid = (state==FULL). Outputs hold stable while o_valid && !i_ready.
- Reset (any time, including mid-MUL): state IDLE, any in-flight operation is discarded. o_data 0, o_valid 0, o_zero 0, o_ovf 0, o_carry 0, o_err 0. o_ready is 1 once reset deasserts.

## Timing
- Non-MUL latency 1: accepted at edge N, o_valid high after edge N.
- Throughput: one op per cycle when i_ready is held high.
- MUL latency NB_DATA+1: accept at edge N, BUSY for edges N+1..N+NB_DATA, o_valid high after edge N+NB_DATA+1 (edge N+9 for NB_DATA=8).
- Simultaneous drain and accept in FULL: old result retires, new result (or BUSY) takes effect at the same edge. There is no bubble for non-MUL ops.
- i_ready while o_valid is low is ignored.
- i_valid while o_ready is low is not accepted; the source must hold it.

## Configuration
- ALU_SEQ_MUL_EN defined: MUL opcode supported, BUSY state and accumulator/counter logic present.
- ALU_SEQ_MUL_EN undefined: no BUSY state or multiplier logic. MUL is treated as an unsupported opcode: 1-cycle latency, o_err=1, o_data=0, o_zero=1.

## Test plan
- ADD A=0x7F, B=0x01 -> o_data 0x80, o_ovf 1, o_carry 0, o_zero 0, one cycle after accept. SUB A=0x00, B=0x01 -> 0xFF, o_carry 1, o_ovf 0.
- SRA A=0x80, B=0x09 (amount 1) -> 0xC0. SRL same operands -> 0x40. SLL A=0x81, B=0x01 -> 0x02. SLT A=0xFF, B=0x01 -> 0x01.
- MUL (macro on) A=0xFD (−3), B=0x05 -> 0xF1, o_ovf 0, o_valid exactly 9 edges after accept, o_ready 0 throughout BUSY. Then A=0x10, B=0x10 -> 0x00, o_zero 1, o_ovf 1.
- Back-pressure: hold i_ready=0 with ADD 3+4 pending and i_valid high with a second op -> o_data stays 0x07, o_ready 0. Raise i_ready -> second op accepted at the same edge, its result appears next cycle.
- Opcode 111111 -> o_err 1, o_data 0x00, o_zero 1. With the macro off, MUL -> o_err 1 after 1 cycle.
- Assert i_reset 4 cycles into a MUL -> all outputs 0 immediately (asynchronous). After deassert: o_ready 1, o_valid 0, and no stale result appears.
